// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data-memory stage.
//   size_e        access size encoding (B/H/W/D)
//   out_state_e   output-side states of mem_access_unit
//   op_info_t     per-op side information carried from accept to result
//   byte_enable() per-byte write enable for a sized access at a byte lane
//   load_extract() pulls the addressed bytes out of a RAM word and extends them
// Both helpers work at MAX_XLEN; a 32-bit datapath zero-extends its word on
// the way in and truncates the result on the way out.
package mem_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_BYTES = MAX_XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } out_state_e;

  typedef struct packed {
    logic [2:0] lane;
    size_e      size;
    logic       ld_unsigned;
    logic       do_load;
    logic       mem_to_reg;
    logic       fault_misalign;
    logic       fault_oob;
  } op_info_t;

  function automatic logic [MAX_BYTES-1:0] byte_enable(input size_e sz, input logic [2:0] lane);
    logic [MAX_BYTES-1:0] mask;
    case (sz)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << lane;
  endfunction

  function automatic logic [MAX_XLEN-1:0] load_extract(input logic [MAX_XLEN-1:0] word,
                                                       input logic [2:0]          lane,
                                                       input size_e               sz,
                                                       input logic                zero_ext);
    logic [MAX_XLEN-1:0] sh;
    logic [MAX_XLEN-1:0] res;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_B:    res = zero_ext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_H:    res = zero_ext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    res = zero_ext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous RAM with per-byte write enables and a
// registered read port. Contents are never reset.
//   clk    rising-edge clock
//   re     read enable; rdata updates only when asserted, otherwise it holds
//   we     write enable, qualified per byte by be
//   be     byte enables, one per 8-bit lane of the word
//   addr   word index
//   wdata  write data, already shifted onto its byte lanes
//   rdata  registered read data
module data_ram #(
  parameter int    WIDTH     = 64,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory pipeline stage between execute and writeback.
// Accepts one load/store/pass-through op per cycle (in_valid/in_ready) and
// returns its writeback value one cycle later (out_valid/out_ready), holding
// the result stable under downstream stall.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake
//   mem_read/mem_write/mem_to_reg/size/ld_unsigned/address/write_data
//                     request fields
//   out_valid/out_ready result handshake
//   wd                writeback value (load data or address)
//   fault_misalign    access not aligned to its size (or illegal size)
//   fault_oob         access beyond the end of the RAM
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int    XLEN      = 64,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wd,
  output logic            fault_misalign,
  output logic            fault_oob
);

  localparam int NB         = XLEN / 8;
  localparam int BYTE_SHIFT = $clog2(NB);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  out_state_e      state_q, state_d;
  op_info_t        op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] hold_wd_q, hold_wd_d;
  logic            hold_mis_q, hold_mis_d;
  logic            hold_oob_q, hold_oob_d;

  logic            accept;
  size_e           req_size;
  logic [2:0]      req_lane;
  logic            req_mem_op;
  logic            req_mis;
  logic            req_oob;
  logic            req_fault;

  logic            ram_re;
  logic            ram_we;
  logic [NB-1:0]   ram_be;
  logic [IDX_W-1:0] ram_idx;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_rdata;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] fresh_wd;

  // Request decode: fault checks, RAM control and store lane alignment.
  // Faults only apply to ops that actually touch memory; a pass-through op
  // just forwards its address. A doubly-flagged read+write op is a store.
  always_comb begin
    accept     = in_valid && in_ready;
    req_size   = size_e'(size);
    req_lane   = 3'(address[BYTE_SHIFT-1:0]);
    req_mem_op = mem_read || mem_write;
    case (req_size)
      SZ_B:    req_mis = 1'b0;
      SZ_H:    req_mis = address[0];
      SZ_W:    req_mis = |address[1:0];
      default: req_mis = (XLEN == 32) ? 1'b1 : |address[2:0];
    endcase
    req_mis   = req_mis && req_mem_op;
    req_oob   = req_mem_op && ((address >> BYTE_SHIFT) >= XLEN'(DEPTH));
    req_fault = req_mis || req_oob;

    ram_idx   = address[BYTE_SHIFT +: IDX_W];
    ram_be    = NB'(byte_enable(req_size, req_lane));
    ram_wdata = write_data << {req_lane, 3'b000};
    ram_we    = accept && mem_write && !req_fault;
    ram_re    = accept && mem_read && !mem_write && !req_fault;

    op_d   = op_q;
    addr_d = addr_q;
    if (accept) begin
      op_d.lane           = req_lane;
      op_d.size           = req_size;
      op_d.ld_unsigned    = ld_unsigned;
      op_d.do_load        = mem_read && !mem_write && !req_fault;
      op_d.mem_to_reg     = mem_to_reg;
      op_d.fault_misalign = req_mis;
      op_d.fault_oob      = req_oob;
      addr_d              = address;
    end
  end

  data_ram #(
    .WIDTH     (XLEN),
    .DEPTH     (DEPTH),
    .ADDR_W    (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Result formed from the RAM word read last cycle. The RAM read port only
  // fires on an accepted load, so during a stall this value does not move.
  always_comb begin
    load_data = '0;
    if (op_q.do_load) begin
      load_data = XLEN'(load_extract(MAX_XLEN'(ram_rdata), op_q.lane, op_q.size, op_q.ld_unsigned));
    end
    fresh_wd = op_q.mem_to_reg ? load_data : addr_q;

    hold_wd_d  = hold_wd_q;
    hold_mis_d = hold_mis_q;
    hold_oob_d = hold_oob_q;
    if ((state_q == ST_FRESH) && !out_ready) begin
      hold_wd_d  = fresh_wd;
      hold_mis_d = op_q.fault_misalign;
      hold_oob_d = op_q.fault_oob;
    end
  end

  // Datapath registers: op side information and the stall hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      hold_wd_q  <= '0;
      hold_mis_q <= 1'b0;
      hold_oob_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      hold_wd_q  <= hold_wd_d;
      hold_mis_q <= hold_mis_d;
      hold_oob_q <= hold_oob_d;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Output FSM next state. A stalled FRESH result moves into the hold
  // register (HELD); any consumed result is replaced by a new accept or
  // leaves the stage empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FRESH;
      ST_FRESH: begin
        if (!out_ready)  state_d = ST_HELD;
        else if (accept) state_d = ST_FRESH;
        else             state_d = ST_EMPTY;
      end
      ST_HELD: begin
        if (out_ready) state_d = accept ? ST_FRESH : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output FSM outputs. An empty stage drives zeros so reset clears wd and
  // the fault flags immediately.
  always_comb begin
    out_valid      = 1'b0;
    wd             = '0;
    fault_misalign = 1'b0;
    fault_oob      = 1'b0;
    in_ready       = out_ready;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_FRESH: begin
        out_valid      = 1'b1;
        wd             = fresh_wd;
        fault_misalign = op_q.fault_misalign;
        fault_oob      = op_q.fault_oob;
      end
      ST_HELD: begin
        out_valid      = 1'b1;
        wd             = hold_wd_q;
        fault_misalign = hold_mis_q;
        fault_oob      = hold_oob_q;
      end
      default: in_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit (XLEN=64,
// DEPTH=1024). A byte-array reference model predicts each result when an op
// is accepted; results are queued and compared in order as they appear.
module tb_mem_access_unit;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic [1:0]      size;
  logic            ld_unsigned;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] write_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] wd;
  logic            fault_misalign;
  logic            fault_oob;

  always #5 clk = ~clk;

  mem_access_unit #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .size           (size),
    .ld_unsigned    (ld_unsigned),
    .address        (address),
    .write_data     (write_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .wd             (wd),
    .fault_misalign (fault_misalign),
    .fault_oob      (fault_oob)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        m2r;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct packed {
    logic [63:0] wd;
    logic        mis;
    logic        oob;
  } res_t;

  typedef struct {
    op_t         op;
    logic [63:0] exp_wd;
    logic        exp_mis;
    logic        exp_oob;
  } vec_t;

  logic [7:0] ref_mem [NBYTES];
  res_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         accepted = 0;
  int         consumed = 0;

  function automatic op_t mkOp(input logic rd, input logic wr, input logic m2r, input logic [1:0] sz,
                               input logic uns, input logic [63:0] addr, input logic [63:0] wdata);
    op_t o;
    o.rd = rd; o.wr = wr; o.m2r = m2r; o.sz = sz; o.uns = uns; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  // Reference model: byte-addressed memory, sizes as byte counts.
  function automatic res_t modelOp(input op_t op);
    res_t        r;
    int          nb;
    logic        memop;
    logic        mis;
    logic        oob;
    logic [63:0] ld;
    nb    = 1 << op.sz;
    memop = op.rd || op.wr;
    mis   = memop && ((op.addr % 64'(nb)) != 64'd0);
    oob   = memop && (op.addr >= 64'(NBYTES));
    ld    = 64'd0;
    if (op.wr) begin
      if (!mis && !oob) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(op.addr) + i] = op.wdata[8*i +: 8];
      end
    end else if (op.rd && !mis && !oob) begin
      for (int i = nb - 1; i >= 0; i--) ld = (ld << 8) | 64'(ref_mem[int'(op.addr) + i]);
      if (!op.uns && nb < 8 && ld[8*nb-1]) ld = ld | (~64'd0 << (8*nb));
    end
    r.wd  = op.m2r ? ld : op.addr;
    r.mis = mis;
    r.oob = oob;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, then check outputs against
  // the model and account for the handshakes that will fire on the next
  // rising edge.
  task automatic applyStimulus(input op_t op, input logic valid, input logic ready);
    logic exp_iready;
    @(negedge clk);
    in_valid    = valid;
    mem_read    = op.rd;
    mem_write   = op.wr;
    mem_to_reg  = op.m2r;
    size        = op.sz;
    ld_unsigned = op.uns;
    address     = op.addr;
    write_data  = op.wdata;
    out_ready   = ready;
    #1;
    checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      checkOutput("wd", wd, exp_q[0].wd);
      checkOutput("fault_misalign", 64'(fault_misalign), 64'(exp_q[0].mis));
      checkOutput("fault_oob", 64'(fault_oob), 64'(exp_q[0].oob));
    end
    exp_iready = (exp_q.size() == 0) || ready;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_iready));
    if (exp_q.size() > 0 && ready) begin
      void'(exp_q.pop_front());
      consumed++;
    end
    if (valid && exp_iready) begin
      exp_q.push_back(modelOp(op));
      accepted++;
    end
  endtask

  initial begin
    op_t         idle;
    op_t         op;
    vec_t        vecs[20];
    logic [63:0] held;

    idle = mkOp(0, 0, 0, 0, 0, 64'd0, 64'd0);

    // Directed vectors: store/load patterns, faults and boundaries.
    vecs[0]  = '{mkOp(0,1,0,3,0,64'h10,  64'h8877665544332211), 64'h10,                 0, 0};
    vecs[1]  = '{mkOp(1,0,1,0,0,64'h17,  64'h0),                64'hFFFFFFFFFFFFFF88,   0, 0};
    vecs[2]  = '{mkOp(1,0,1,0,1,64'h17,  64'h0),                64'h88,                 0, 0};
    vecs[3]  = '{mkOp(0,1,0,3,0,64'h20,  64'h0123456789ABCDEF), 64'h20,                 0, 0};
    vecs[4]  = '{mkOp(0,1,0,1,0,64'h22,  64'h111122223333BEEF), 64'h22,                 0, 0};
    vecs[5]  = '{mkOp(1,0,1,3,0,64'h20,  64'h0),                64'h01234567BEEFCDEF,   0, 0};
    vecs[6]  = '{mkOp(1,0,1,2,0,64'h13,  64'h0),                64'h0,                  1, 0};
    vecs[7]  = '{mkOp(0,1,0,2,0,64'h13,  64'hDEADBEEF),         64'h13,                 1, 0};
    vecs[8]  = '{mkOp(1,0,1,3,0,64'h10,  64'h0),                64'h8877665544332211,   0, 0};
    vecs[9]  = '{mkOp(1,0,1,3,0,64'h2000,64'h0),                64'h0,                  0, 1};
    vecs[10] = '{mkOp(1,0,1,2,0,64'h2002,64'h0),                64'h0,                  1, 1};
    vecs[11] = '{mkOp(0,0,0,0,0,64'h1234,64'h0),                64'h1234,               0, 0};
    vecs[12] = '{mkOp(1,0,1,1,0,64'h22,  64'h0),                64'hFFFFFFFFFFFFBEEF,   0, 0};
    vecs[13] = '{mkOp(1,0,1,1,1,64'h22,  64'h0),                64'hBEEF,               0, 0};
    vecs[14] = '{mkOp(1,0,1,2,0,64'h14,  64'h0),                64'hFFFFFFFF88776655,   0, 0};
    vecs[15] = '{mkOp(1,0,1,2,1,64'h14,  64'h0),                64'h88776655,           0, 0};
    vecs[16] = '{mkOp(1,1,1,0,0,64'h18,  64'hAA),               64'h0,                  0, 0};
    vecs[17] = '{mkOp(1,0,1,0,1,64'h18,  64'h0),                64'hAA,                 0, 0};
    vecs[18] = '{mkOp(0,1,0,3,0,64'h1FF8,64'hCAFEF00DDEADBEEF), 64'h1FF8,               0, 0};
    vecs[19] = '{mkOp(1,0,1,3,0,64'h1FF8,64'h0),                64'hCAFEF00DDEADBEEF,   0, 0};

    rst_n = 1'b0;
    in_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; size = 0;
    ld_unsigned = 0; address = '0; write_data = '0; out_ready = 0;
    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_wd", wd, 64'd0);
    checkOutput("reset_faults", {62'd0, fault_misalign, fault_oob}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(idle, 0, 1);

    // Fill every word so later loads see defined data.
    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(mkOp(0, 1, 0, 3, 0, 64'(w * 8), {$urandom, $urandom}), 1, 1);
    end
    applyStimulus(idle, 0, 1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].op, 1, 1);
      applyStimulus(idle, 0, 1);
      checkOutput($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d_wd", i), wd, vecs[i].exp_wd);
      checkOutput($sformatf("vec%0d_mis", i), 64'(fault_misalign), 64'(vecs[i].exp_mis));
      checkOutput($sformatf("vec%0d_oob", i), 64'(fault_oob), 64'(vecs[i].exp_oob));
    end

    // Store immediately followed by a load of the same bytes.
    applyStimulus(mkOp(0, 1, 0, 2, 0, 64'h30, 64'h12345678), 1, 1);
    applyStimulus(mkOp(1, 0, 1, 2, 1, 64'h30, 64'h0), 1, 1);
    applyStimulus(idle, 0, 1);
    checkOutput("st_ld_fwd", wd, 64'h12345678);

    // Back-to-back loads with out_ready low for three cycles.
    applyStimulus(mkOp(1, 0, 1, 3, 0, 64'h10, 64'h0), 1, 1);
    applyStimulus(mkOp(1, 0, 1, 3, 0, 64'h20, 64'h0), 1, 0);
    held = wd;
    checkOutput("stall_first_wd", wd, 64'h8877665544332211);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(mkOp(1, 0, 1, 3, 0, 64'h20, 64'h0), 1, 0);
      checkOutput("stall_wd_hold", wd, held);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    end
    applyStimulus(mkOp(1, 0, 1, 3, 0, 64'h20, 64'h0), 1, 1);
    applyStimulus(mkOp(1, 0, 1, 1, 1, 64'h22, 64'h0), 1, 1);
    checkOutput("stall_second_wd", wd, 64'h01234567BEEFCDEF);
    applyStimulus(idle, 0, 1);
    checkOutput("stall_third_wd", wd, 64'hBEEF);
    applyStimulus(idle, 0, 1);

    // Reset with a stalled store result in flight; the store itself stays.
    applyStimulus(mkOp(0, 1, 0, 3, 0, 64'h40, 64'h5A5A0F0F12344321), 1, 0);
    applyStimulus(idle, 0, 0);
    checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_wd", wd, 64'd0);
    consumed += exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(mkOp(1, 0, 1, 3, 0, 64'h40, 64'h0), 1, 1);
    applyStimulus(idle, 0, 1);
    checkOutput("postrst_store_kept", wd, 64'h5A5A0F0F12344321);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int kind;
      kind     = $urandom_range(0, 9);
      op.sz    = 2'($urandom_range(0, 3));
      op.uns   = 1'($urandom_range(0, 1));
      op.m2r   = 1'($urandom_range(0, 1));
      op.wdata = {$urandom, $urandom};
      op.rd    = (kind < 5) || (kind == 9);
      op.wr    = (kind >= 5 && kind < 8) || (kind == 9);
      op.addr  = 64'($urandom_range(0, NBYTES - 1));
      if ((op.rd || op.wr) && $urandom_range(0, 9) == 0) op.addr = op.addr + 64'(NBYTES);
      if (!(op.rd || op.wr) || $urandom_range(0, 3) != 0) begin
        op.addr = op.addr & ~(64'(1 << op.sz) - 64'd1);
      end
      applyStimulus(op, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(idle, 0, 1);
    applyStimulus(idle, 0, 1);
    checkOutput("order_count", 64'(consumed), 64'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
